// File: rtl/res_block_pkg.sv
// Shared arithmetic helpers for the residual block: saturation, leaky ReLU,
// tensor flat indexing and accumulator sizing.
package res_block_pkg;

  localparam int unsigned WideW = 64;
  typedef logic signed [WideW-1:0] wide_t;

  function automatic wide_t sat(input wide_t value, input int unsigned width);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Negative values are floored by the arithmetic shift, matching the reference model.
  function automatic wide_t lrelu(input wide_t v, input logic slope_small);
    if (v < 0) return slope_small ? (v >>> 7) : (v >>> 3);
    return v;
  endfunction

  function automatic int unsigned flat_idx(input int unsigned n, input int unsigned c,
                                           input int unsigned h, input int unsigned w,
                                           input int unsigned ch, input int unsigned ht,
                                           input int unsigned wd);
    return ((n * ch + c) * ht + h) * wd + w;
  endfunction

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ch,
                                            input int unsigned k);
    return 2 * dw + $clog2(ch * k * k) + 1;
  endfunction

endpackage

// File: rtl/conv2d_same.sv
// Combinational same-size 2D convolution with a fixed identity centre-tap kernel,
// zero padding at the borders and a saturated DW-bit result.
module conv2d_same
  import res_block_pkg::*;
#(
  parameter int unsigned IN_CH  = 1,
  parameter int unsigned OUT_CH = 1,
  parameter int unsigned K      = 1,
  parameter int unsigned DW     = 8,
  parameter int unsigned BATCH  = 1,
  parameter int unsigned HEIGHT = 2,
  parameter int unsigned WIDTH  = 2
) (
  input  logic [BATCH*IN_CH*HEIGHT*WIDTH*DW-1:0]  x_i,
  output logic [BATCH*OUT_CH*HEIGHT*WIDTH*DW-1:0] y_o
);

  localparam int unsigned InTot  = BATCH * IN_CH * HEIGHT * WIDTH * DW;
  localparam int unsigned OutTot = BATCH * OUT_CH * HEIGHT * WIDTH * DW;
  localparam int unsigned Pad    = (K - 1) / 2;
  localparam int unsigned Centre = K / 2;
  localparam int unsigned MinCh  = (IN_CH < OUT_CH) ? IN_CH : OUT_CH;
  localparam int unsigned AccW   = acc_width(DW, IN_CH, K);
  localparam int unsigned KernW  = OUT_CH * IN_CH * K * K * DW;

  function automatic int unsigned wt_idx(input int unsigned o, input int unsigned i,
                                         input int unsigned kh, input int unsigned kw);
    return ((o * IN_CH + i) * K + kh) * K + kw;
  endfunction

  function automatic logic [KernW-1:0] build_kernel();
    logic [KernW-1:0] kern;
    kern = '0;
    for (int o = 0; o < int'(MinCh); o++) begin
      kern[wt_idx(o, o, Centre, Centre)*DW +: DW] = DW'(1);
    end
    return kern;
  endfunction

  localparam logic [KernW-1:0] Kernel = build_kernel();

  always_comb begin
    logic signed [AccW-1:0] acc;
    logic signed [2*DW-1:0] prod;
    logic signed [DW-1:0]   xv;
    logic signed [DW-1:0]   wv;
    int                     ih;
    int                     iw;
    acc  = '0;
    prod = '0;
    xv   = '0;
    wv   = '0;
    ih   = 0;
    iw   = 0;
    y_o  = '0;
    for (int n = 0; n < int'(BATCH); n++) begin
      for (int o = 0; o < int'(OUT_CH); o++) begin
        for (int h = 0; h < int'(HEIGHT); h++) begin
          for (int w = 0; w < int'(WIDTH); w++) begin
            acc = '0;
            for (int i = 0; i < int'(IN_CH); i++) begin
              for (int kh = 0; kh < int'(K); kh++) begin
                for (int kw = 0; kw < int'(K); kw++) begin
                  ih = h + kh - int'(Pad);
                  iw = w + kw - int'(Pad);
                  // Taps falling outside the tensor contribute zero.
                  if (ih >= 0 && ih < int'(HEIGHT) && iw >= 0 && iw < int'(WIDTH)) begin
                    xv   = x_i[InTot-1-flat_idx(n, i, ih, iw, IN_CH, HEIGHT, WIDTH)*DW -: DW];
                    wv   = Kernel[wt_idx(o, i, kh, kw)*DW +: DW];
                    prod = (2*DW)'(xv) * (2*DW)'(wv);
                    acc  = acc + AccW'(prod);
                  end
                end
              end
            end
            y_o[OutTot-1-flat_idx(n, o, h, w, OUT_CH, HEIGHT, WIDTH)*DW -: DW] =
                DW'(sat(wide_t'(acc), DW));
          end
        end
      end
    end
  end

endmodule

// File: rtl/res_block.sv
// Residual block x + conv2(lrelu(conv1(pre(x)))) on a flat tensor bus,
// three register stages with the raw input delayed to stay aligned with conv2.
module res_block
  import res_block_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned BATCH_SIZE      = 1,
  parameter int unsigned CHANNELS        = 1,
  parameter int unsigned HEIGHT          = 2,
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned KERNEL_SIZE     = 1,
  parameter int unsigned STRIDE          = 1,
  parameter int unsigned PADDING         = 0,
  parameter bit          SLOPE_SMALL     = 1'b0,
  parameter bit          START_FROM_RELU = 1'b0,
  parameter bit          END_WITH_RELU   = 1'b0,
  parameter bit          BOTTLENECK      = 1'b0
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic [BATCH_SIZE*CHANNELS*HEIGHT*WIDTH*DATA_WIDTH-1:0]    x_in,
  output logic [BATCH_SIZE*CHANNELS*HEIGHT*WIDTH*DATA_WIDTH-1:0]    x_out
);

  localparam int unsigned Dw     = DATA_WIDTH;
  localparam int unsigned Elems  = BATCH_SIZE * CHANNELS * HEIGHT * WIDTH;
  localparam int unsigned Tot    = Elems * Dw;
  localparam int unsigned Mid    = BOTTLENECK ? ((CHANNELS / 2 < 1) ? 1 : CHANNELS / 2)
                                              : CHANNELS;
  localparam int unsigned HidEl  = BATCH_SIZE * Mid * HEIGHT * WIDTH;
  localparam int unsigned HidTot = HidEl * Dw;

  if (STRIDE != 1) begin : g_bad_stride
    $error("res_block: STRIDE must be 1");
  end
  if (PADDING != (KERNEL_SIZE - 1) / 2) begin : g_bad_padding
    $error("res_block: PADDING must equal (KERNEL_SIZE-1)/2");
  end
  if (KERNEL_SIZE % 2 == 0) begin : g_bad_kernel
    $error("res_block: KERNEL_SIZE must be odd");
  end

  logic [Tot-1:0]    s1_x_q, s1_x_d;
  logic [Tot-1:0]    s1_pre_q, s1_pre_d;
  logic [HidTot-1:0] s2_h_q, s2_h_d;
  logic [Tot-1:0]    s2_x_q, s2_x_d;
  logic [Tot-1:0]    x_out_q, x_out_d;
  logic [HidTot-1:0] conv1_y;
  logic [Tot-1:0]    conv2_y;

  conv2d_same #(
    .IN_CH (CHANNELS),
    .OUT_CH(Mid),
    .K     (KERNEL_SIZE),
    .DW    (Dw),
    .BATCH (BATCH_SIZE),
    .HEIGHT(HEIGHT),
    .WIDTH (WIDTH)
  ) u_conv1 (
    .x_i(s1_pre_q),
    .y_o(conv1_y)
  );

  conv2d_same #(
    .IN_CH (Mid),
    .OUT_CH(CHANNELS),
    .K     (KERNEL_SIZE),
    .DW    (Dw),
    .BATCH (BATCH_SIZE),
    .HEIGHT(HEIGHT),
    .WIDTH (WIDTH)
  ) u_conv2 (
    .x_i(s2_h_q),
    .y_o(conv2_y)
  );

  always_comb begin
    s1_x_d   = x_in;
    s1_pre_d = x_in;
    if (START_FROM_RELU) begin
      for (int e = 0; e < int'(Elems); e++) begin
        s1_pre_d[Tot-1-e*Dw -: Dw] =
            Dw'(lrelu(wide_t'($signed(x_in[Tot-1-e*Dw -: Dw])), SLOPE_SMALL));
      end
    end
  end

  always_comb begin
    s2_h_d = '0;
    s2_x_d = s1_x_q;
    for (int e = 0; e < int'(HidEl); e++) begin
      s2_h_d[HidTot-1-e*Dw -: Dw] =
          Dw'(lrelu(wide_t'($signed(conv1_y[HidTot-1-e*Dw -: Dw])), SLOPE_SMALL));
    end
  end

  always_comb begin
    wide_t sum;
    sum     = '0;
    x_out_d = '0;
    for (int e = 0; e < int'(Elems); e++) begin
      sum = wide_t'($signed(s2_x_q[Tot-1-e*Dw -: Dw]))
          + wide_t'($signed(conv2_y[Tot-1-e*Dw -: Dw]));
      sum = sat(sum, Dw);
      if (END_WITH_RELU) begin
        sum = lrelu(sum, SLOPE_SMALL);
      end
      x_out_d[Tot-1-e*Dw -: Dw] = Dw'(sum);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_x_q   <= '0;
      s1_pre_q <= '0;
      s2_h_q   <= '0;
      s2_x_q   <= '0;
      x_out_q  <= '0;
    end else begin
      s1_x_q   <= s1_x_d;
      s1_pre_q <= s1_pre_d;
      s2_h_q   <= s2_h_d;
      s2_x_q   <= s2_x_d;
      x_out_q  <= x_out_d;
    end
  end

  assign x_out = x_out_q;

endmodule

// File: tb/tb_res_block.sv
// Bench for res_block: five parameterisations share one stimulus bus and are checked
// against a per-element arithmetic model with a three-edge pipeline delay.
module tb_res_block;

  localparam int unsigned Bw = 288;

  logic          clk  = 1'b0;
  logic          rst  = 1'b0;
  logic [Bw-1:0] stim = '0;
  logic [31:0]   out_a, out_b, out_c;
  logic [63:0]   out_d;
  logic [287:0]  out_e;

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  logic [Bw-1:0] pend[$];
  string         names[$];

  always #5 clk = ~clk;

  res_block u_a (.clk(clk), .rst(rst), .x_in(stim[Bw-1 -: 32]), .x_out(out_a));

  res_block #(.SLOPE_SMALL(1'b1)) u_b (
    .clk(clk), .rst(rst), .x_in(stim[Bw-1 -: 32]), .x_out(out_b)
  );

  res_block #(.START_FROM_RELU(1'b1), .END_WITH_RELU(1'b1)) u_c (
    .clk(clk), .rst(rst), .x_in(stim[Bw-1 -: 32]), .x_out(out_c)
  );

  res_block #(.CHANNELS(2), .BOTTLENECK(1'b1)) u_d (
    .clk(clk), .rst(rst), .x_in(stim[Bw-1 -: 64]), .x_out(out_d)
  );

  res_block #(
    .BATCH_SIZE(2), .CHANNELS(2), .HEIGHT(3), .WIDTH(3), .KERNEL_SIZE(3), .PADDING(1)
  ) u_e (
    .clk(clk), .rst(rst), .x_in(stim), .x_out(out_e)
  );

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int lr(input int v, input bit slope_small);
    if (v >= 0) return v;
    return slope_small ? (v >>> 7) : (v >>> 3);
  endfunction

  // Identity centre taps reduce each conv to a per-element copy for channels below M.
  function automatic logic [Bw-1:0] model(input logic [Bw-1:0] in, input int tot,
                                          input int chans, input int hw, input int mid,
                                          input bit slope, input bit start, input bit endr);
    logic [Bw-1:0] res;
    res = '0;
    for (int i = 0; i < tot; i++) begin
      int x;
      int c;
      int hid;
      int y;
      x   = int'($signed(in[Bw-1-i*8 -: 8]));
      c   = (i / hw) % chans;
      hid = lr(sat8(start ? lr(x, slope) : x), slope);
      y   = sat8(x + ((c < mid) ? sat8(hid) : 0));
      if (endr) y = lr(y, slope);
      res[Bw-1-i*8 -: 8] = y[7:0];
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [Bw-1:0] obs, input logic [Bw-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [Bw-1:0] e, input bit zero);
    check({tag, "/A"}, {out_a, 256'd0}, zero ? '0 : model(e, 4, 1, 4, 1, 1'b0, 1'b0, 1'b0));
    check({tag, "/B"}, {out_b, 256'd0}, zero ? '0 : model(e, 4, 1, 4, 1, 1'b1, 1'b0, 1'b0));
    check({tag, "/C"}, {out_c, 256'd0}, zero ? '0 : model(e, 4, 1, 4, 1, 1'b0, 1'b1, 1'b1));
    check({tag, "/D"}, {out_d, 224'd0}, zero ? '0 : model(e, 8, 2, 4, 1, 1'b0, 1'b0, 1'b0));
    check({tag, "/E"}, out_e, zero ? '0 : model(e, 36, 2, 9, 2, 1'b0, 1'b0, 1'b0));
  endtask

  // Apply one tensor, clock once, then compare against the tensor applied two edges earlier.
  task automatic cycle(input logic [Bw-1:0] v, input string name);
    logic [Bw-1:0] e;
    string         t;
    stim = v;
    pend.push_back(v);
    names.push_back(name);
    @(posedge clk);
    #1;
    if (pend.size() == 3) begin
      e = pend.pop_front();
      t = names.pop_front();
      check_all(t, e, 1'b0);
    end else begin
      check_all({name, "_fill"}, '0, 1'b1);
    end
  endtask

  function automatic logic [Bw-1:0] fill4(input int a, input int b, input int c, input int d);
    logic [Bw-1:0] r;
    int            p[4];
    p = '{a, b, c, d};
    r = '0;
    for (int i = 0; i < 36; i++) r[Bw-1-i*8 -: 8] = 8'(p[i % 4]);
    return r;
  endfunction

  function automatic logic [Bw-1:0] fill_ch(input int v0, input int v1);
    logic [Bw-1:0] r;
    r = '0;
    for (int i = 0; i < 36; i++) r[Bw-1-i*8 -: 8] = 8'(((i / 4) % 2 == 0) ? v0 : v1);
    return r;
  endfunction

  function automatic logic [Bw-1:0] rand_vec();
    logic [Bw-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[Bw-1-k*32 -: 32] = $urandom();
    return r;
  endfunction

  initial begin
    rst  = 1'b0;
    stim = fill4(9, 9, 9, 9);
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset", '0, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    cycle(fill4(1, 2, 3, 4), "ramp");
    cycle(fill4(-16, -16, -16, -16), "neg16");
    cycle(fill4(100, -100, 127, -128), "sat");
    cycle(fill_ch(5, 7), "bneck");
    cycle(fill4(-128, -1, 0, 127), "edges");
    for (int k = 0; k < 40; k++) cycle(rand_vec(), "rand1");

    // Asynchronous reset lands between edges while tensors are in flight.
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", '0, 1'b1);
    pend.delete();
    names.delete();
    stim = rand_vec();
    @(posedge clk);
    #1;
    check_all("held_rst", '0, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 60; k++) cycle(rand_vec(), "rand2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
